// File: rtl/sal_bk_pkg.sv
// Shared types for the per-bank DDR2 controller: command encoding, bank FSM
// states and the request holding-register layout.
package sal_bk_pkg;

  localparam int unsigned SAL_RA_W  = 14;
  localparam int unsigned SAL_CA_W  = 10;
  localparam int unsigned SAL_ID_W  = 4;
  localparam int unsigned SAL_LEN_W = 4;

  typedef enum logic [2:0] {
    ACT = 3'd0,
    RD  = 3'd1,
    WR  = 3'd2,
    PRE = 3'd3,
    REF = 3'd4
  } sal_cmd_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_REFRESH
  } bk_state_t;

  // Field widths are the maximum supported; instances slice down to their own widths.
  typedef struct packed {
    logic                 wr;
    logic [SAL_RA_W-1:0]  ra;
    logic [SAL_CA_W-1:0]  ca;
    logic [SAL_ID_W-1:0]  id;
    logic [SAL_LEN_W-1:0] len;
  } sal_bk_req_t;

endpackage

// File: rtl/sal_timing_cnt.sv
// Load/decrement timing counter: loads value-1 and counts down to zero.
// With MaxLoad set, a load never shortens a window that is still running.
module sal_timing_cnt #(
  parameter int unsigned TW      = 5,
  parameter bit          MaxLoad = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic [TW-1:0] val_i,
  output logic          zero_o
);

  logic [TW-1:0] cnt_q;
  logic [TW-1:0] dec_val;
  logic [TW-1:0] load_val;

  always_comb begin
    dec_val  = (val_i == '0) ? '0 : val_i - 1'b1;
    load_val = (MaxLoad && (cnt_q > dec_val)) ? cnt_q : dec_val;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/sal_bk_ctrl_gen.sv
// Per-bank DDR2 controller: holds one request, tracks the open row and bank
// timing, and offers ACT/RD/WR/PRE/REF to the command scheduler.
module sal_bk_ctrl_gen
  import sal_bk_pkg::*;
#(
  parameter int unsigned BA         = 0,
  parameter int unsigned BA_W       = 3,
  parameter int unsigned RA_W       = 14,
  parameter int unsigned CA_W       = 10,
  parameter int unsigned ID_W       = 4,
  parameter int unsigned LEN_W      = 4,
  parameter int unsigned TW         = 5,
  parameter bit          CLOSE_PAGE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [TW-1:0]    t_rcd_i,
  input  logic [TW-1:0]    t_ras_i,
  input  logic [TW-1:0]    t_rp_i,
  input  logic [TW-1:0]    t_rtp_i,
  input  logic [TW-1:0]    t_wtp_i,
  input  logic [TW-1:0]    t_rfc_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_wr_i,
  input  logic [RA_W-1:0]  req_ra_i,
  input  logic [CA_W-1:0]  req_ca_i,
  input  logic [ID_W-1:0]  req_id_i,
  input  logic [LEN_W-1:0] req_len_i,
  output logic             cmd_valid_o,
  output logic [2:0]       cmd_type_o,
  input  logic             cmd_gnt_i,
  output logic [BA_W-1:0]  cmd_ba_o,
  output logic [RA_W-1:0]  cmd_ra_o,
  output logic [CA_W-1:0]  cmd_ca_o,
  output logic [ID_W-1:0]  cmd_id_o,
  output logic [LEN_W-1:0] cmd_len_o,
  input  logic             ref_req_i,
  output logic             ref_gnt_o
);

  bk_state_t       state_q;
  sal_bk_req_t     pend_q;
  logic            pend_vld_q;
  logic [RA_W-1:0] cur_ra_q;

  logic            rcd_zero, ras_zero, c2p_zero, busy_zero;
  logic [RA_W-1:0] pend_ra;
  logic            hit, miss, grant;
  logic            act_ld, col_ld, pre_ld, ref_ld;
  sal_cmd_t        cmd_type;

  assign pend_ra = pend_q.ra[RA_W-1:0];
  assign hit     = pend_vld_q && (pend_ra == cur_ra_q);
  assign miss    = pend_vld_q && (pend_ra != cur_ra_q);

  always_comb begin
    cmd_valid_o = 1'b0;
    cmd_type    = ACT;
    cmd_ba_o    = '0;
    cmd_ra_o    = '0;
    cmd_ca_o    = '0;
    cmd_id_o    = '0;
    cmd_len_o   = '0;
    unique case (state_q)
      S_IDLE: begin
        if (ref_req_i && busy_zero) begin
          cmd_valid_o = 1'b1;
          cmd_type    = REF;
          cmd_ba_o    = BA_W'(BA);
        end else if (pend_vld_q && busy_zero) begin
          cmd_valid_o = 1'b1;
          cmd_type    = ACT;
          cmd_ba_o    = BA_W'(BA);
          cmd_ra_o    = pend_ra;
        end
      end
      S_ACTIVE: begin
        if (hit && rcd_zero) begin
          cmd_valid_o = 1'b1;
          cmd_type    = pend_q.wr ? WR : RD;
          cmd_ba_o    = BA_W'(BA);
          cmd_ra_o    = cur_ra_q;
          cmd_ca_o    = pend_q.ca[CA_W-1:0];
          cmd_id_o    = pend_q.id[ID_W-1:0];
          cmd_len_o   = pend_q.len[LEN_W-1:0];
        end else if (ras_zero && c2p_zero &&
                     (miss || ((ref_req_i || CLOSE_PAGE) && !hit))) begin
          cmd_valid_o = 1'b1;
          cmd_type    = PRE;
          cmd_ba_o    = BA_W'(BA);
          cmd_ra_o    = cur_ra_q;
        end
      end
      default: ;
    endcase
  end

  assign cmd_type_o  = cmd_type;
  assign grant       = cmd_valid_o && cmd_gnt_i;
  assign act_ld      = grant && (cmd_type == ACT);
  assign col_ld      = grant && ((cmd_type == RD) || (cmd_type == WR));
  assign pre_ld      = grant && (cmd_type == PRE);
  assign ref_ld      = grant && (cmd_type == REF);
  assign ref_gnt_o   = ref_ld;
  assign req_ready_o = !pend_vld_q && !ref_req_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pend_vld_q <= 1'b0;
      pend_q     <= '0;
      cur_ra_q   <= '0;
    end else begin
      if (req_valid_i && req_ready_o) begin
        pend_vld_q <= 1'b1;
        pend_q     <= '{wr:  req_wr_i,
                        ra:  SAL_RA_W'(req_ra_i),
                        ca:  SAL_CA_W'(req_ca_i),
                        id:  SAL_ID_W'(req_id_i),
                        len: SAL_LEN_W'(req_len_i)};
      end else if (col_ld) begin
        pend_vld_q <= 1'b0;
      end
      unique case (state_q)
        S_IDLE: begin
          if (act_ld) begin
            state_q  <= S_ACTIVE;
            cur_ra_q <= pend_ra;
          end else if (ref_ld) begin
            state_q <= S_REFRESH;
          end
        end
        S_ACTIVE:  if (pre_ld) state_q <= S_IDLE;
        S_REFRESH: if (busy_zero) state_q <= S_IDLE;
        default:   state_q <= S_IDLE;
      endcase
    end
  end

  sal_timing_cnt #(.TW(TW), .MaxLoad(1'b0)) u_rcd_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (act_ld),
    .val_i  (t_rcd_i),
    .zero_o (rcd_zero)
  );

  sal_timing_cnt #(.TW(TW), .MaxLoad(1'b0)) u_ras_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (act_ld),
    .val_i  (t_ras_i),
    .zero_o (ras_zero)
  );

  // A read issued inside a write's recovery window must not shorten it.
  sal_timing_cnt #(.TW(TW), .MaxLoad(1'b1)) u_c2p_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (col_ld),
    .val_i  ((cmd_type == WR) ? t_wtp_i : t_rtp_i),
    .zero_o (c2p_zero)
  );

  sal_timing_cnt #(.TW(TW), .MaxLoad(1'b0)) u_busy_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (pre_ld || ref_ld),
    .val_i  (pre_ld ? t_rp_i : t_rfc_i),
    .zero_o (busy_zero)
  );

  gnt_only_when_valid: assert property (@(posedge clk) disable iff (!rst_n)
    cmd_gnt_i |-> cmd_valid_o);
  no_act_while_busy: assert property (@(posedge clk) disable iff (!rst_n)
    (cmd_valid_o && (cmd_type == ACT)) |-> busy_zero);

endmodule
